// File: rtl/calc_engine.sv
// Sequential four-function calculator: latches A/B/Op on a synchronised "equals"
// press, then produces a 2*WIDTH-bit result with Busy/Done/Err status.
module calc_engine #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Key,
  input  logic [1:0]           Op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Result,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int FW = $clog2(SS + 1);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [FW-1:0] FLUSH_DONE = FW'(SS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t               state_r, state_nxt_s;
  logic [SS-1:0]        sync_r;
  logic [FW-1:0]        flush_r;
  logic                 armed_r;
  logic                 prev_r;
  logic                 key_sync_s;
  logic                 detect_s;
  logic                 start_s;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [WIDTH-1:0]     acc_r, mq_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 busy_r, done_r, err_r;
  logic [WIDTH:0]       sum_s, shifted_s;
  logic [WIDTH-1:0]     diff_s, acc_nxt_s, mq_nxt_s;
  logic [2*WIDTH-1:0]   exec_res_s;
  logic                 exec_err_s;

  assign key_sync_s = sync_r[SS-1];
  // The pipeline must be flushed and a released level seen before any press
  // counts, so a key held through reset release cannot start an operation.
  assign detect_s   = armed_r & prev_r & ~key_sync_s;

  // Key synchroniser, flush counter, arming flag and previous-level register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r  <= {SS{1'b1}};
      flush_r <= {FW{1'b0}};
      armed_r <= 1'b0;
      prev_r  <= 1'b1;
    end else begin
      sync_r  <= {sync_r[SS-2:0], Key};
      prev_r  <= key_sync_s;
      if (flush_r != FLUSH_DONE) begin
        flush_r <= flush_r + {{(FW-1){1'b0}}, 1'b1};
      end
      if ((flush_r == FLUSH_DONE) && key_sync_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (detect_s) begin
          start_s = 1'b1;
          if (Op == 2'b10) begin
            state_nxt_s = RUN;
          end else if ((Op == 2'b11) && (B != {WIDTH{1'b0}})) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = EXEC;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      EXEC: state_nxt_s = DONE;
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    sum_s     = mq_r[0] ? ({1'b0, acc_r} + {1'b0, a_r}) : {1'b0, acc_r};
    shifted_s = {acc_r, mq_r[WIDTH-1]};
    diff_s    = shifted_s[WIDTH-1:0] - b_r;
    if (op_r == 2'b11) begin
      if (shifted_s >= {1'b0, b_r}) begin
        acc_nxt_s = diff_s;
        mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = shifted_s[WIDTH-1:0];
        mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = sum_s[WIDTH:1];
      mq_nxt_s  = {sum_s[0], mq_r[WIDTH-1:1]};
    end
  end

  // Single-cycle results: add, subtract, divide by zero
  always_comb begin
    exec_err_s = 1'b0;
    case (op_r)
      2'b00: exec_res_s = {{WIDTH{1'b0}}, a_r} + {{WIDTH{1'b0}}, b_r};
      2'b01: exec_res_s = {{WIDTH{1'b0}}, a_r} - {{WIDTH{1'b0}}, b_r};
      2'b11: begin
        exec_res_s = {(2*WIDTH){1'b1}};
        exec_err_s = 1'b1;
      end
      default: exec_res_s = {(2*WIDTH){1'b0}};
    endcase
  end

  // Operand capture, iteration datapath and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r     <= 2'b00;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mq_r     <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else if (start_s) begin
      op_r   <= Op;
      a_r    <= A;
      b_r    <= B;
      acc_r  <= {WIDTH{1'b0}};
      mq_r   <= (Op == 2'b10) ? B : A;
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b1;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (state_r == EXEC) begin
      result_r <= exec_res_s;
      err_r    <= exec_err_s;
      busy_r   <= 1'b0;
      done_r   <= 1'b1;
    end else if (state_r == RUN) begin
      acc_r <= acc_nxt_s;
      mq_r  <= mq_nxt_s;
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      if (cnt_r == CNT_LAST) begin
        result_r <= {acc_nxt_s, mq_nxt_s};
        busy_r   <= 1'b0;
        done_r   <= 1'b1;
      end
    end
  end

  assign Result = result_r;
  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Err    = err_r;

endmodule

// File: tb/tb_calc_engine.sv
// Directed, table-driven bench for calc_engine with hand-computed results,
// plus sequences for ignored presses, held keys and mid-operation reset.
module tb_calc_engine;

  logic        clk;
  logic        reset;
  logic        Key;
  logic [1:0]  Op;
  logic [7:0]  A, B;
  logic [15:0] Result;
  logic        Busy, Done, Err;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  calc_engine #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .Key(Key), .Op(Op), .A(A), .B(B),
    .Result(Result), .Busy(Busy), .Done(Done), .Err(Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Press Key, wait for Busy, scramble inputs, count Busy cycles.
  task automatic press_and_run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic release_key, output int lat, output logic started,
                               output logic done_at_start);
    int w;
    A = a; B = b; Op = op;
    Key = 1'b0;
    w = 0;
    started = 1'b0;
    done_at_start = 1'b1;
    while (!Busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    lat = 0;
    if (Busy) begin
      started = 1'b1;
      done_at_start = Done;
      A = ~a; B = ~b; Op = ~op;
      while (Busy && lat < 40) begin
        lat++;
        @(negedge clk);
      end
    end
    if (release_key) Key = 1'b1;
  endtask

  initial begin
    int          lat;
    logic        st, d0;

    vecs[0]  = '{2'b00, 8'd200, 8'd100, 16'h012C, 1'b0, 1};
    vecs[1]  = '{2'b01, 8'd5,   8'd9,   16'hFFFC, 1'b0, 1};
    vecs[2]  = '{2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 8};
    vecs[3]  = '{2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 8};
    vecs[4]  = '{2'b11, 8'd9,   8'd0,   16'hFFFF, 1'b1, 1};
    vecs[5]  = '{2'b00, 8'd255, 8'd255, 16'h01FE, 1'b0, 1};
    vecs[6]  = '{2'b01, 8'd0,   8'd255, 16'hFF01, 1'b0, 1};
    vecs[7]  = '{2'b10, 8'd0,   8'd77,  16'h0000, 1'b0, 8};
    vecs[8]  = '{2'b10, 8'd16,  8'd16,  16'h0100, 1'b0, 8};
    vecs[9]  = '{2'b11, 8'd7,   8'd200, 16'h0700, 1'b0, 8};
    vecs[10] = '{2'b11, 8'd255, 8'd1,   16'h00FF, 1'b0, 8};
    vecs[11] = '{2'b11, 8'd100, 8'd10,  16'h000A, 1'b0, 8};

    reset = 1'b0; Key = 1'b1; Op = 2'b00; A = 8'd0; B = 8'd0;
    cycles(3);
    chk("reset_result", {16'd0, Result}, 32'h0);
    chk("reset_busy", {31'd0, Busy}, 32'h0);
    chk("reset_done", {31'd0, Done}, 32'h0);
    chk("reset_err", {31'd0, Err}, 32'h0);
    reset = 1'b1;
    cycles(10);
    chk("idle_busy", {31'd0, Busy}, 32'h0);
    chk("idle_done", {31'd0, Done}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      press_and_run(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, lat, st, d0);
      chk($sformatf("v%0d_started", i), {31'd0, st}, 32'h1);
      chk($sformatf("v%0d_done_cleared", i), {31'd0, d0}, 32'h0);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), {16'd0, Result}, {16'd0, vecs[i].res});
      chk($sformatf("v%0d_err", i), {31'd0, Err}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_done", i), {31'd0, Done}, 32'h1);
      cycles(4);
    end

    // Second press during a multiply is ignored
    A = 8'd255; B = 8'd255; Op = 2'b10; Key = 1'b0;
    for (int w = 0; w < 20 && !Busy; w++) @(negedge clk);
    chk("ign_started", {31'd0, Busy}, 32'h1);
    Key = 1'b1; A = 8'd3; B = 8'd4; Op = 2'b00;
    cycles(1);
    Key = 1'b0;
    lat = 1;
    while (Busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_latency", lat, 8);
    chk("ign_result", {16'd0, Result}, 32'h0000FE01);
    cycles(10);
    chk("ign_no_restart_busy", {31'd0, Busy}, 32'h0);
    chk("ign_result_hold", {16'd0, Result}, 32'h0000FE01);
    chk("ign_done_hold", {31'd0, Done}, 32'h1);
    Key = 1'b1;
    cycles(4);

    // Reset in the middle of a multiply, with Key held low across release
    A = 8'd13; B = 8'd11; Op = 2'b10; Key = 1'b0;
    for (int w = 0; w < 20 && !Busy; w++) @(negedge clk);
    chk("rst_mid_started", {31'd0, Busy}, 32'h1);
    cycles(4);
    reset = 1'b0;
    #1;
    chk("rst_mid_result", {16'd0, Result}, 32'h0);
    chk("rst_mid_busy", {31'd0, Busy}, 32'h0);
    chk("rst_mid_done", {31'd0, Done}, 32'h0);
    cycles(2);
    reset = 1'b1;
    A = 8'd1; B = 8'd2; Op = 2'b00;
    cycles(15);
    chk("held_key_busy", {31'd0, Busy}, 32'h0);
    chk("held_key_done", {31'd0, Done}, 32'h0);
    chk("held_key_result", {16'd0, Result}, 32'h0);
    Key = 1'b1;
    cycles(5);
    press_and_run(2'b00, 8'd1, 8'd2, 1'b1, lat, st, d0);
    chk("after_rst_started", {31'd0, st}, 32'h1);
    chk("after_rst_result", {16'd0, Result}, 32'h00000003);
    chk("after_rst_done", {31'd0, Done}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
- Consumer of the two stored 8-bit operands held by the operand memory block: A on Out7..Out0, B on Out15..Out8.
- On an active-low "equals" push-button press, the block latches A, B and an operation code, then computes the result sequentially.
- Add and subtract take 1 cycle; multiply (shift-add) and divide (restoring) take WIDTH cycles.
- The 16-bit result is presented to the display path with Done/Busy/Err status.

Parameters:
- WIDTH, 8, operand width; Result is 2*WIDTH bits; multiply/divide iteration count = WIDTH.
- SYNC_STAGES, 2, flip-flop stages synchronising the asynchronous Key input (minimum 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- Key  input  1  active-low push-button "equals", asynchronous to clk.
- Op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div; sampled at press.
- A  input  WIDTH  operand A (unsigned), sampled at press.
- B  input  WIDTH  operand B (unsigned), sampled at press.
- Result  output  2*WIDTH  computed result.
- Busy  output  1  high while computing.
- Done  output  1  high while Result is valid.
- Err  output  1  divide-by-zero flag, valid with Done.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; Result=0, Busy=0, Done=0, Err=0.
  - Synchroniser flops preset to 1 (released-button level), so reset release never produces a press.
- Press detection:
  - Key passes through SYNC_STAGES flops.
  - A press is the synchronised level going 1->0 (registered previous-value compare), giving one detect pulse per press.
  - Holding Key low does not repeat. Bounce is handled externally.
- States: IDLE, EXEC, RUN, DONE.
- IDLE/DONE + detect at edge D:
  - Latch A, B and Op into internal registers.
  - Clear Done and Err, set Busy.
  - Op 00/01 -> EXEC. Op 10 -> RUN. Op 11 with B!=0 -> RUN. Op 11 with B==0 -> EXEC.
- EXEC (one cycle), at edge D+1 write Result, then go to DONE:
  - add: zero-extended A+B.
  - sub: A-B as 2*WIDTH-bit two's complement (A, B zero-extended before subtracting).
  - div-by-zero: Result = all ones, Err=1.
- RUN:
  - Iteration counter 0..WIDTH-1, one iteration per cycle.
  - mul: shift-add over B bits, product = A*B (unsigned, full 2*WIDTH bits).
  - div: restoring division of A by B; Result = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
  - Final iteration at edge D+WIDTH writes Result, then go to DONE.
- Busy/Done timing:
  - Busy=1 from after edge D until Result is written.
  - Done=1 (and Busy=0) from the same edge that writes Result.
  - Latency from detect: 1 cycle for add/sub/div0; WIDTH cycles (8) for mul/div.
- DONE:
  - Result, Done and Err hold indefinitely.
  - A new detect starts a new operation; Done drops the cycle after edge D.
- Presses while in EXEC or RUN are ignored (not queued).
- A/B/Op changes after edge D do not affect the running operation.
- Asynchronous reset mid-RUN aborts immediately to IDLE with all outputs 0.
- Internal arithmetic must not lose carries: the mul accumulator and the div partial remainder are WIDTH+1 bits where needed.

Test Plan:
- Reset then release with Key=1 -> Result=0x0000, Done=0, Busy=0; no operation starts.
- A=200, B=100, Op=00, press -> Done 1 cycle after detect, Result=0x012C, Err=0.
- A=5, B=9, Op=01, press -> Result=0xFFFC.
- A=255, B=255, Op=10, press -> Busy exactly 8 cycles, then Result=0xFE01, Done=1.
  - Second press during Busy -> ignored; Result still 0xFE01.
- A=200, B=7, Op=11, press -> after 8 cycles Result=0x041C (r=4, q=28).
  - A=9, B=0, Op=11 -> 1 cycle, Result=0xFFFF, Err=1.
- Start mul, assert reset at iteration 4 -> outputs 0 immediately, state IDLE.
  - Holding Key low across reset release -> no operation starts until Key is released and pressed again.
